// File: rtl/pwm8_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in clk cycles,
// reporting on each rising edge and flagging a stuck input after TIMEOUT quiet cycles.
module pwm8_capture #(
    // 10 bits so the period counter can actually reach the 512-cycle timeout
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_i,
    output logic [7:0]       duty_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             stuck_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

    logic             s1, s2, s3;
    logic             rise;
    logic             armed;
    logic             to_done;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [7:0]       high_sat;
    logic             timeout_hit;

    assign rise        = s2 & ~s3;
    assign high_sat    = (high_cnt > CNT_W'(255)) ? 8'hFF : high_cnt[7:0];
    assign timeout_hit = ~rise & (period_cnt >= TO_LIM) & ~to_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
        end else begin
            if (period_cnt != CNT_MAX) begin
                period_cnt <= period_cnt + CNT_ONE;
            end
            if (s2 && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + CNT_ONE;
            end
        end
    end

    // A rise only reports once armed; a timeout disarms so the next rise starts a fresh period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b0;
            to_done  <= 1'b0;
            duty_o   <= '0;
            period_o <= '0;
            stuck_o  <= 1'b0;
            valid_o  <= 1'b0;
        end else if (rise) begin
            to_done <= 1'b0;
            if (armed) begin
                duty_o   <= high_sat;
                period_o <= period_cnt;
                stuck_o  <= 1'b0;
                valid_o  <= 1'b1;
            end else begin
                armed   <= 1'b1;
                valid_o <= 1'b0;
            end
        end else if (timeout_hit) begin
            duty_o   <= s2 ? 8'hFF : 8'h00;
            period_o <= '0;
            stuck_o  <= 1'b1;
            valid_o  <= 1'b1;
            to_done  <= 1'b1;
            armed    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm8_capture.sv
// Scoreboard bench for pwm8_capture: a sample-stream reference model predicts reports,
// a monitor checks every strobe and the held outputs between strobes.
module tb_pwm8_capture;

    localparam int CNT_W   = 10;
    localparam int TIMEOUT = 512;
    localparam int MAXS    = 65536;

    typedef struct {
        logic [7:0]       duty;
        logic [CNT_W-1:0] period;
        logic             stuck;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pwm_i = 1'b0;
    logic [7:0]       duty_o;
    logic [CNT_W-1:0] period_o;
    logic             valid_o;
    logic             stuck_o;

    int   tests = 0;
    int   fails = 0;
    int   edge_idx = 0;
    bit   samp [0:MAXS-1];
    exp_t exp_q [$];
    exp_t last = '{duty: 8'h00, period: '0, stuck: 1'b0, due: 0};

    pwm8_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_i    (pwm_i),
        .duty_o   (duty_o),
        .period_o (period_o),
        .valid_o  (valid_o),
        .stuck_o  (stuck_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_idx);
        end
    endtask

    // A strobe registered at edge due is seen by downstream flops on the following edge,
    // i.e. the 3rd edge after the one that first sampled the input high.
    task automatic checkOutput(input exp_t e);
        check_val("report_duty", int'(duty_o), int'(e.duty));
        check_val("report_period", int'(period_o), int'(e.period));
        check_val("report_stuck", int'(stuck_o), int'(e.stuck));
        check_val("report_edge", edge_idx, e.due);
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            pwm_i = level;
        end
    endtask

    // 8-bit generator: 256-cycle frame, high while the phase counter is below duty.
    task automatic run_generator(input int duty, input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int p = 0; p < 256; p++) begin
                @(negedge clk);
                pwm_i = (p < duty);
            end
        end
    endtask

    // Reference model over the stream of clk-sampled input values: a report is due two edges
    // after the sample at which the input first reads high, covering the span since the previous one.
    initial begin
        int  n;
        int  ref_idx;
        int  h;
        bit  armed_m;
        bit  to_fired;
        bit  in_reset;
        exp_t e;
        ref_idx  = 0;
        armed_m  = 1'b0;
        to_fired = 1'b0;
        in_reset = 1'b1;
        forever begin
            @(posedge clk);
            edge_idx++;
            n = edge_idx;
            if (n >= MAXS) continue;
            if (!rst) begin
                samp[n]  = 1'b0;
                armed_m  = 1'b0;
                in_reset = 1'b1;
                exp_q.delete();
            end else begin
                samp[n] = pwm_i;
                if (in_reset) begin
                    ref_idx  = n - 2;
                    to_fired = 1'b0;
                    in_reset = 1'b0;
                end
                if (samp[n] && !samp[n-1]) begin
                    if (armed_m) begin
                        h = 0;
                        for (int i = ref_idx; i < n; i++) h += int'(samp[i]);
                        e.duty   = (h > 255) ? 8'd255 : 8'(h);
                        e.period = CNT_W'(n - ref_idx);
                        e.stuck  = 1'b0;
                        e.due    = n + 2;
                        exp_q.push_back(e);
                    end
                    armed_m  = 1'b1;
                    ref_idx  = n;
                    to_fired = 1'b0;
                end else if (!to_fired && (n - ref_idx >= TIMEOUT)) begin
                    e.duty   = samp[n] ? 8'hFF : 8'h00;
                    e.period = '0;
                    e.stuck  = 1'b1;
                    e.due    = n + 2;
                    exp_q.push_back(e);
                    to_fired = 1'b1;
                    armed_m  = 1'b0;
                end
            end
        end
    end

    // Monitor: every strobe must match the oldest pending report; between strobes outputs hold.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last = '{duty: 8'h00, period: '0, stuck: 1'b0, due: 0};
                continue;
            end
            while (exp_q.size() > 0 && exp_q[0].due < edge_idx) begin
                tests++;
                fails++;
                $display("[TB] FAIL missing_strobe: no valid_o at edge %0d, expected at edge %0d",
                         edge_idx, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_strobe: valid_o=1 at edge %0d, expected 0", edge_idx);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput(cur);
                    last = cur;
                end
            end else begin
                tests++;
                if (duty_o !== last.duty || period_o !== last.period || stuck_o !== last.stuck) begin
                    fails++;
                    $display("[TB] FAIL hold: got duty=%0d period=%0d stuck=%0d, expected duty=%0d period=%0d stuck=%0d",
                             duty_o, period_o, stuck_o, last.duty, last.period, last.stuck);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_generator(64, 4);
        run_generator(1, 2);
        run_generator(128, 2);
        run_generator(255, 2);
        run_generator(0, 3);
        run_generator(200, 3);

        applyStimulus(1'b1, 1000);
        applyStimulus(1'b0, 20);

        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, 300);
            applyStimulus(1'b0, 100);
        end

        for (int r = 0; r < 6; r++) begin
            applyStimulus(1'b1, 1);
            applyStimulus(1'b0, 1);
        end

        run_generator(96, 2);
        run_generator(96, 0);
        applyStimulus(1'b1, 50);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("async_reset_duty", int'(duty_o), 0);
        check_val("async_reset_period", int'(period_o), 0);
        check_val("async_reset_valid", int'(valid_o), 0);
        check_val("async_reset_stuck", int'(stuck_o), 0);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        run_generator(160, 3);

        for (int r = 0; r < 20; r++) begin
            applyStimulus(1'b1, $urandom_range(1, 300));
            applyStimulus(1'b0, $urandom_range(1, 300));
        end
        for (int r = 0; r < 3; r++) begin
            run_generator($urandom_range(1, 255), 2);
        end

        applyStimulus(1'b0, 4);
        check_val("pending_reports_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
